// File: rtl/err_event_monitor_pkg.sv
// Shared defaults and helpers for the error-event monitor slice.
package err_event_monitor_pkg;

    localparam int DEF_N_CH        = 2;
    localparam int DEF_CNT_SZ      = 5;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TS_SZ       = 16;

    // Ceiling log2, never smaller than 1 so an index port always has a bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/err_event_monitor_ev_chan.sv
// One monitored event channel: synchroniser, rising-edge detect,
// saturating event counter and sticky overflow flag.
module ev_chan
    import err_event_monitor_pkg::*;
#(
    parameter int CNT_SZ      = DEF_CNT_SZ,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              ev,
    input  logic              clr,
    output logic              pulse,
    output logic [CNT_SZ-1:0] cnt,
    output logic              ovf
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   sync_out;

    assign sync_out = sync[SYNC_STAGES-1];
    assign pulse    = sync_out & ~prev;

    // Synchroniser chain and previous-value flop; untouched by the clears.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync[0] <= ev;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
            prev <= sync_out;
        end
    end

    // Saturating counter; a clear that meets a pulse leaves one event counted.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= pulse ? CNT_SZ'(1) : '0;
            ovf <= 1'b0;
        end else if (pulse) begin
            if (cnt == {CNT_SZ{1'b1}}) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CNT_SZ'(1);
            end
        end
    end

endmodule

// File: rtl/err_event_monitor.sv
// Error-event monitor: per-channel edge counters plus a free-running
// timestamp, most-recent-event record and threshold interrupt.
module err_event_monitor
    import err_event_monitor_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int CNT_SZ      = DEF_CNT_SZ,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TS_SZ       = DEF_TS_SZ
) (
    input  logic                          CLK,
    input  logic                          RST_n,
    input  logic [N_CH-1:0]               I_EV,
    input  logic [N_CH-1:0]               I_CLR,
    input  logic                          I_CLR_ALL,
    input  logic [CNT_SZ-1:0]             I_THR,
    input  logic [N_CH-1:0]               I_IRQ_MASK,
    output logic [N_CH-1:0]               O_EV_PULSE,
    output logic [N_CH*CNT_SZ-1:0]        O_CNT,
    output logic [N_CH-1:0]               O_OVF,
    output logic [N_CH-1:0]               O_THR_HIT,
    output logic                          O_IRQ,
    output logic [clog2_min1(N_CH)-1:0]   O_LAST_CH,
    output logic [TS_SZ-1:0]              O_LAST_TS,
    output logic [TS_SZ-1:0]              O_TS
);

    localparam int LCH_W = clog2_min1(N_CH);

    logic [CNT_SZ-1:0] cnt_arr [N_CH];
    logic [LCH_W-1:0]  low_idx;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ev_chan #(
            .CNT_SZ      (CNT_SZ),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ev_chan (
            .CLK   (CLK),
            .RST_n (RST_n),
            .ev    (I_EV[g]),
            .clr   (I_CLR[g] | I_CLR_ALL),
            .pulse (O_EV_PULSE[g]),
            .cnt   (cnt_arr[g]),
            .ovf   (O_OVF[g])
        );

        assign O_CNT[g*CNT_SZ +: CNT_SZ] = cnt_arr[g];
    end

    // Threshold compare against the registered counters; zero threshold disables.
    always_comb begin
        O_THR_HIT = '0;
        for (int i = 0; i < N_CH; i++) begin
            O_THR_HIT[i] = (I_THR != '0) && (cnt_arr[i] >= I_THR);
        end
    end

    assign O_IRQ = |(O_THR_HIT & I_IRQ_MASK);

    // Lowest-numbered channel pulsing this cycle.
    always_comb begin
        low_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (O_EV_PULSE[i]) begin
                low_idx = LCH_W'(i);
            end
        end
    end

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            O_TS <= '0;
        end else begin
            O_TS <= O_TS + TS_SZ'(1);
        end
    end

    // Last-event record; a capture takes priority over clear-all.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            O_LAST_CH <= '0;
            O_LAST_TS <= '0;
        end else if (|O_EV_PULSE) begin
            O_LAST_CH <= low_idx;
            O_LAST_TS <= O_TS;
        end else if (I_CLR_ALL) begin
            O_LAST_CH <= '0;
            O_LAST_TS <= '0;
        end
    end

endmodule

// File: tb/tb_err_event_monitor.sv
// Self-checking bench for err_event_monitor with a per-event scoreboard.
module tb_err_event_monitor;
    import err_event_monitor_pkg::*;

    localparam int N_CH        = 2;
    localparam int CNT_SZ      = 5;
    localparam int SYNC_STAGES = 2;
    localparam int TS_SZ       = 16;
    localparam int CMAX        = (1 << CNT_SZ) - 1;

    logic                   CLK;
    logic                   RST_n;
    logic [N_CH-1:0]        I_EV;
    logic [N_CH-1:0]        I_CLR;
    logic                   I_CLR_ALL;
    logic [CNT_SZ-1:0]      I_THR;
    logic [N_CH-1:0]        I_IRQ_MASK;
    logic [N_CH-1:0]        O_EV_PULSE;
    logic [N_CH*CNT_SZ-1:0] O_CNT;
    logic [N_CH-1:0]        O_OVF;
    logic [N_CH-1:0]        O_THR_HIT;
    logic                   O_IRQ;
    logic [0:0]             O_LAST_CH;
    logic [TS_SZ-1:0]       O_LAST_TS;
    logic [TS_SZ-1:0]       O_TS;

    typedef struct {
        int ch;
        int cnt;
        bit ovf;
    } exp_t;

    exp_t             sb_q [$];
    int               model_cnt [N_CH];
    bit               model_ovf [N_CH];
    logic [TS_SZ-1:0] ts_model;
    int               n_checks;
    int               n_fail;

    err_event_monitor #(
        .N_CH        (N_CH),
        .CNT_SZ      (CNT_SZ),
        .SYNC_STAGES (SYNC_STAGES),
        .TS_SZ       (TS_SZ)
    ) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .I_EV       (I_EV),
        .I_CLR      (I_CLR),
        .I_CLR_ALL  (I_CLR_ALL),
        .I_THR      (I_THR),
        .I_IRQ_MASK (I_IRQ_MASK),
        .O_EV_PULSE (O_EV_PULSE),
        .O_CNT      (O_CNT),
        .O_OVF      (O_OVF),
        .O_THR_HIT  (O_THR_HIT),
        .O_IRQ      (O_IRQ),
        .O_LAST_CH  (O_LAST_CH),
        .O_LAST_TS  (O_LAST_TS),
        .O_TS       (O_TS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Independent timestamp reference
    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) ts_model <= '0;
        else        ts_model <= ts_model + 1'b1;
    end

    function automatic int cnt_of(input int ch);
        return int'(O_CNT[ch*CNT_SZ +: CNT_SZ]);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_n = 1'b0;
        step(2);
        RST_n = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            model_cnt[i] = 0;
            model_ovf[i] = 1'b0;
        end
        sb_q.delete();
    endtask

    // Generate one rising edge on ch, optionally clearing in the same cycle,
    // and check the scoreboard entry when the counter update lands.
    task automatic fire(input int ch, input bit clr_with);
        bit   got;
        exp_t e;
        if (clr_with) begin
            model_cnt[ch] = 1;
            model_ovf[ch] = 1'b0;
        end else if (model_cnt[ch] == CMAX) begin
            model_ovf[ch] = 1'b1;
        end else begin
            model_cnt[ch] = model_cnt[ch] + 1;
        end
        sb_q.push_back('{ch, model_cnt[ch], model_ovf[ch]});
        I_EV[ch] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge CLK);
            if (O_EV_PULSE[ch]) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("[TB] FAIL pulse_timeout ch%0d: saw none, required one within 6 cycles", ch);
        end
        if (clr_with) I_CLR[ch] = 1'b1;
        @(negedge CLK);
        I_CLR[ch] = 1'b0;
        e = sb_q.pop_front();
        n_checks += 4;
        if (cnt_of(e.ch) !== e.cnt) begin
            n_fail++;
            $display("[TB] FAIL cnt ch%0d: got %0d, required %0d", e.ch, cnt_of(e.ch), e.cnt);
        end
        if (O_OVF[e.ch] !== e.ovf) begin
            n_fail++;
            $display("[TB] FAIL ovf ch%0d: got %0b, required %0b", e.ch, O_OVF[e.ch], e.ovf);
        end
        if (O_EV_PULSE[e.ch] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL pulse_width ch%0d: got %0b, required 0", e.ch, O_EV_PULSE[e.ch]);
        end
        if (int'(O_LAST_CH) !== e.ch) begin
            n_fail++;
            $display("[TB] FAIL last_ch: got %0d, required %0d", O_LAST_CH, e.ch);
        end
        I_EV[ch] = 1'b0;
        step(3);
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        #12;
        n_checks++;
        if ({O_EV_PULSE, O_CNT, O_OVF, O_THR_HIT, O_IRQ, O_LAST_CH, O_LAST_TS, O_TS} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got cnt=%h ts=%h last_ts=%h, required all 0", O_CNT, O_TS, O_LAST_TS);
        end
        RST_n = 1'b1;
    endtask

    task automatic test_held_high();
        int npulse;
        int first_k;
        do_reset();
        I_EV[0] = 1'b1;
        npulse  = 0;
        first_k = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            if (O_EV_PULSE[0]) begin
                npulse++;
                if (first_k < 0) first_k = k;
            end
            if (k == 3) begin
                n_checks++;
                if (cnt_of(0) !== 1) begin
                    n_fail++;
                    $display("[TB] FAIL held_cnt_latency: got %0d, required 1", cnt_of(0));
                end
            end
        end
        n_checks += 3;
        if (npulse !== 1) begin
            n_fail++;
            $display("[TB] FAIL held_pulse_count: got %0d, required 1", npulse);
        end
        if (first_k !== SYNC_STAGES) begin
            n_fail++;
            $display("[TB] FAIL held_pulse_cycle: got %0d, required %0d", first_k, SYNC_STAGES);
        end
        I_EV[0] = 1'b0;
        step(5);
        if (cnt_of(0) !== 1) begin
            n_fail++;
            $display("[TB] FAIL fall_no_count: got %0d, required 1", cnt_of(0));
        end
    endtask

    task automatic test_reset_release_high();
        int npulse;
        I_EV[0] = 1'b1;
        do_reset();
        npulse = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (O_EV_PULSE[0]) npulse++;
        end
        n_checks += 2;
        if (npulse !== 1) begin
            n_fail++;
            $display("[TB] FAIL release_pulses: got %0d, required 1", npulse);
        end
        if (cnt_of(0) !== 1) begin
            n_fail++;
            $display("[TB] FAIL release_cnt: got %0d, required 1", cnt_of(0));
        end
        I_EV[0] = 1'b0;
        step(3);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int p = 0; p < 35; p++) fire(1, 1'b0);
        I_CLR[1] = 1'b1;
        @(negedge CLK);
        I_CLR[1] = 1'b0;
        @(negedge CLK);
        n_checks += 2;
        if (cnt_of(1) !== 0) begin
            n_fail++;
            $display("[TB] FAIL clr_cnt ch1: got %0d, required 0", cnt_of(1));
        end
        if (O_OVF[1] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clr_ovf ch1: got %0b, required 0", O_OVF[1]);
        end
    endtask

    task automatic test_threshold();
        do_reset();
        I_THR      = 5'd3;
        I_IRQ_MASK = 2'b01;
        fire(0, 1'b0);
        fire(0, 1'b0);
        n_checks++;
        if (O_THR_HIT !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL thr_below: got %b, required 00", O_THR_HIT);
        end
        fire(0, 1'b0);
        n_checks += 4;
        if (O_THR_HIT !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL thr_hit: got %b, required 01", O_THR_HIT);
        end
        if (O_IRQ !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL irq_on: got %b, required 1", O_IRQ);
        end
        I_IRQ_MASK = 2'b00;
        #1;
        if (O_IRQ !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL irq_masked: got %b, required 0", O_IRQ);
        end
        I_THR = 5'd0;
        #1;
        if (O_THR_HIT !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL thr_disabled: got %b, required 00", O_THR_HIT);
        end
    endtask

    task automatic test_simultaneous();
        int guard;
        do_reset();
        guard = 0;
        while (O_TS !== 16'd98 && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        I_EV  = 2'b11;
        step(2);
        n_checks += 5;
        if (O_EV_PULSE !== 2'b11 || O_TS !== 16'd100) begin
            n_fail++;
            $display("[TB] FAIL sim_pulse: got pulse=%b ts=%0d, required 11 at 100", O_EV_PULSE, O_TS);
        end
        step(1);
        if (cnt_of(0) !== 1 || cnt_of(1) !== 1) begin
            n_fail++;
            $display("[TB] FAIL sim_cnt: got %0d/%0d, required 1/1", cnt_of(0), cnt_of(1));
        end
        if (O_LAST_CH !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sim_last_ch: got %0d, required 0", O_LAST_CH);
        end
        if (O_LAST_TS !== 16'd100) begin
            n_fail++;
            $display("[TB] FAIL sim_last_ts: got %0d, required 100", O_LAST_TS);
        end
        if (O_TS !== ts_model) begin
            n_fail++;
            $display("[TB] FAIL ts_track: got %0d, required %0d", O_TS, ts_model);
        end
        I_EV = 2'b00;
        step(3);
    endtask

    task automatic test_clear_coincident();
        logic [TS_SZ-1:0] ts_at_pulse;
        int guard;
        do_reset();
        fire(0, 1'b0);
        fire(0, 1'b0);
        fire(0, 1'b1);
        fire(1, 1'b0);
        I_CLR_ALL = 1'b1;
        @(negedge CLK);
        I_CLR_ALL = 1'b0;
        n_checks += 4;
        if (O_CNT !== '0 || O_LAST_CH !== 1'b0 || O_LAST_TS !== '0) begin
            n_fail++;
            $display("[TB] FAIL clr_all: got cnt=%h ch=%0d ts=%0d, required 0/0/0", O_CNT, O_LAST_CH, O_LAST_TS);
        end
        I_EV[1] = 1'b1;
        guard = 0;
        while (O_EV_PULSE[1] !== 1'b1 && guard < 6) begin
            @(negedge CLK);
            guard++;
        end
        ts_at_pulse = ts_model;
        I_CLR_ALL   = 1'b1;
        @(negedge CLK);
        I_CLR_ALL = 1'b0;
        if (O_LAST_CH !== 1'b1 || O_LAST_TS !== ts_at_pulse) begin
            n_fail++;
            $display("[TB] FAIL clr_all_capture: got ch=%0d ts=%0d, required 1/%0d", O_LAST_CH, O_LAST_TS, ts_at_pulse);
        end
        if (cnt_of(1) !== 1) begin
            n_fail++;
            $display("[TB] FAIL clr_all_pulse_cnt: got %0d, required 1", cnt_of(1));
        end
        I_EV[1] = 1'b0;
        step(3);
        model_cnt[0] = 0;
        model_cnt[1] = 1;
        fire(0, 1'b0);
        fire(0, 1'b0);
        #2;
        RST_n = 1'b0;
        #1;
        if ({O_CNT, O_OVF, O_LAST_TS, O_TS, O_EV_PULSE, O_IRQ} !== '0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got cnt=%h ts=%0d, required 0", O_CNT, O_TS);
        end
        RST_n = 1'b1;
    endtask

    task automatic test_ts_wrap();
        int guard;
        do_reset();
        guard = 0;
        while (O_TS !== {TS_SZ{1'b1}} && guard < 70000) begin
            @(negedge CLK);
            guard++;
        end
        n_checks += 2;
        @(negedge CLK);
        if (O_TS !== '0) begin
            n_fail++;
            $display("[TB] FAIL ts_wrap: got %0d, required 0", O_TS);
        end
        step(5);
        if (O_TS !== 16'd5) begin
            n_fail++;
            $display("[TB] FAIL ts_after_wrap: got %0d, required 5", O_TS);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        RST_n      = 1'b1;
        I_EV       = '0;
        I_CLR      = '0;
        I_CLR_ALL  = 1'b0;
        I_THR      = '0;
        I_IRQ_MASK = '0;
        test_reset();
        test_held_high();
        test_reset_release_high();
        test_saturation();
        test_threshold();
        test_simultaneous();
        test_clear_coincident();
        test_ts_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
